glip_out_arbiter: RTL and testbench
===================================

GLIP_OUT_ARBITER -- requirements
Module: glip_out_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width; legal values are 16 or greater.
REQ-002 SHALL have parameter CHANNELS, default 4, number of requester channels; legal range is 2..16.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, per-channel buffer depth in words; power of 2, 4..128.
REQ-004 SHALL have parameter MAX_BURST, default 8, maximum payload words per grant; legal range is 1..FIFO_DEPTH.
REQ-005 SHALL have port clk, input, 1 bit: single clock, logic clock domain.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port ch_in_valid, input, CHANNELS bits: per-channel word valid.
REQ-008 SHALL have port ch_in_ready, output, CHANNELS bits: per-channel buffer not full.
REQ-009 SHALL have port ch_in_data, input, CHANNELS*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port fifo_out_valid, output, 1 bit: GLIP FIFO out valid.
REQ-011 SHALL have port fifo_out_ready, input, 1 bit: GLIP FIFO out ready.
REQ-012 SHALL have port fifo_out_data, output, WIDTH bits: header or payload word.
REQ-013 SHALL have port busy, output, 1 bit: high in HEADER or PAYLOAD state.

Function
REQ-014 SHALL buffer each channel in its own FIFO_DEPTH-word FIFO; a word is written when ch_in_valid[i] and ch_in_ready[i] are both high, and ch_in_ready[i] = not full.
REQ-015 SHALL make a written word count as occupancy from the next cycle (1-cycle write-to-visible latency).
REQ-016 SHALL implement three states: IDLE, HEADER, PAYLOAD.
REQ-017 In IDLE with at least one non-empty channel, SHALL grant by round-robin, searching from rr_ptr upward with wrap-around, capture len = min(occupancy, MAX_BURST), and go to HEADER next cycle.
REQ-018 In IDLE with all channels empty, SHALL stay in IDLE with fifo_out_valid=0.
REQ-019 In HEADER, SHALL drive fifo_out_valid=1 and fifo_out_data = {zeros, len[7:0], channel[7:0]}; on fifo_out_ready, SHALL go to PAYLOAD.
REQ-020 In PAYLOAD, SHALL drive fifo_out_valid=1 and fifo_out_data = head word of the granted channel.
REQ-021 In PAYLOAD, each fifo_out_ready SHALL pop that head word and decrement the remaining count.
REQ-022 When the last word is accepted, SHALL go to IDLE and set rr_ptr = (granted + 1) mod CHANNELS.
REQ-023 SHALL send exactly len payload words; words arriving during the burst SHALL wait for a later grant.
REQ-024 SHALL hold fifo_out_data stable while fifo_out_valid=1 and fifo_out_ready=0.
REQ-025 SHALL never drop fifo_out_valid once it is asserted, until the word is accepted.
REQ-026 On a simultaneous push and pop on the granted channel, SHALL keep occupancy unchanged; at full, ch_in_ready SHALL rise the cycle after the pop.
REQ-027 SHALL not issue back-to-back grants without passing through one IDLE cycle.

Reset
REQ-028 While rst_n=0 at a clk edge, SHALL set: state=IDLE, rr_ptr=0, all FIFOs empty, remaining count=0.
REQ-029 During reset, SHALL drive fifo_out_valid=0, busy=0, ch_in_ready all ones (empty FIFOs), and fifo_out_data all zeros.
REQ-030 On reset in the middle of a burst, SHALL abandon the burst and discard all buffered words; no partial-burst recovery.

Structure
REQ-031 SHALL place the state encoding and the header field offsets (LEN_LSB=8, CH_LSB=0) in the shared package glip_pkg.
REQ-032 SHALL instantiate one sub-module per channel, glip_sync_fifo, a single-clock FIFO with ports push, pop, full, empty, count.

Verification
REQ-033 SHALL cover: channel 2 pushes 3 words (0x1111, 0x2222, 0x3333), ready held high -> output 0x0302, 0x1111, 0x2222, 0x3333, then IDLE.
REQ-034 SHALL cover: channel 0 pushes 20 words, MAX_BURST=8 -> bursts with headers 0x0800, 0x0800, 0x0400, in word order.
REQ-035 SHALL cover: channels 0, 1, 3 each hold 1 word, rr_ptr=0 -> header order 0x0100, 0x0101, 0x0103.
REQ-036 SHALL cover: fifo_out_ready toggles randomly during PAYLOAD -> data stable while stalled, no loss, no duplication.
REQ-037 SHALL cover: channel 1 filled to 16 words -> ch_in_ready[1]=0; after the first payload pop, ch_in_ready[1]=1 the next cycle.
REQ-038 SHALL cover: rst_n pulsed low for 1 cycle mid-PAYLOAD -> fifo_out_valid=0 the next cycle, busy=0, ch_in_ready all ones, no further output without new pushes.

Source files
------------

// File: rtl/glip_pkg.sv
// rtl/glip_pkg.sv - shared state encoding and header layout for the GLIP output arbiter
package glip_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } glip_state_e;

  localparam int LEN_LSB = 8;
  localparam int CH_LSB  = 0;

  function automatic logic [15:0] glip_header(input logic [7:0] len, input logic [7:0] ch);
    logic [15:0] h;
    h = '0;
    h[LEN_LSB +: 8] = len;
    h[CH_LSB +: 8]  = ch;
    return h;
  endfunction

endpackage

// File: rtl/glip_sync_fifo.sv
// rtl/glip_sync_fifo.sv - single-clock per-channel word buffer with occupancy count
module glip_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/glip_out_arbiter.sv
// rtl/glip_out_arbiter.sv - round-robin merge of buffered channels into one GLIP FIFO stream
module glip_out_arbiter
  import glip_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CHANNELS   = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BURST  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       ch_in_valid,
  output logic [CHANNELS-1:0]       ch_in_ready,
  input  logic [CHANNELS*WIDTH-1:0] ch_in_data,
  output logic                      fifo_out_valid,
  input  logic                      fifo_out_ready,
  output logic [WIDTH-1:0]          fifo_out_data,
  output logic                      busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(CHANNELS);

  glip_state_e       state, state_next;
  logic [CHANNELS-1:0] full, empty, push, pop;
  logic [CW-1:0]     count [CHANNELS];
  logic [WIDTH-1:0]  head [CHANNELS];
  logic [PW-1:0]     rr_ptr, grant_ch, pick_ch;
  logic [CW-1:0]     remaining, cnt_sel, len_next;
  logic              pick_found, pop_en;
  int                pick_idx;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign push[g]        = ch_in_valid[g] & ~full[g];
    assign pop[g]         = pop_en && (grant_ch == PW'(g));
    // Outputs are forced to their reset values while rst_n is held low.
    assign ch_in_ready[g] = ~full[g] | ~rst_n;

    glip_sync_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push[g]),
      .wr_data (ch_in_data[g*WIDTH +: WIDTH]),
      .pop     (pop[g]),
      .rd_data (head[g]),
      .full    (full[g]),
      .empty   (empty[g]),
      .count   (count[g])
    );
  end

  // Round-robin search starting at rr_ptr, wrapping past the last channel.
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = '0;
    pick_idx   = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      pick_idx = int'(rr_ptr) + k;
      if (pick_idx >= CHANNELS) pick_idx = pick_idx - CHANNELS;
      if (!pick_found && !empty[PW'(pick_idx)]) begin
        pick_found = 1'b1;
        pick_ch    = PW'(pick_idx);
      end
    end
  end

  assign cnt_sel  = count[pick_ch];
  assign len_next = (cnt_sel > CW'(MAX_BURST)) ? CW'(MAX_BURST) : cnt_sel;
  assign busy     = rst_n && (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    fifo_out_valid = 1'b0;
    fifo_out_data  = '0;
    pop_en         = 1'b0;
    if (rst_n) begin
      case (state)
        ST_IDLE: begin
          if (pick_found) state_next = ST_HEADER;
        end
        ST_HEADER: begin
          fifo_out_valid = 1'b1;
          fifo_out_data  = WIDTH'(glip_header(8'(remaining), 8'(grant_ch)));
          if (fifo_out_ready) state_next = ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          fifo_out_valid = 1'b1;
          fifo_out_data  = head[grant_ch];
          if (fifo_out_ready) begin
            pop_en = 1'b1;
            if (remaining == CW'(1)) state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // remaining holds the burst length during HEADER, then counts down per payload pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      grant_ch  <= '0;
      remaining <= '0;
    end else begin
      if (state == ST_IDLE && pick_found) begin
        grant_ch  <= pick_ch;
        remaining <= len_next;
      end
      if (pop_en) begin
        remaining <= remaining - 1'b1;
        if (remaining == CW'(1))
          rr_ptr <= (grant_ch == PW'(CHANNELS-1)) ? '0 : grant_ch + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_glip_out_arbiter.sv
// tb/tb_glip_out_arbiter.sv - scoreboard bench for the GLIP output arbiter
module tb_glip_out_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ch_in_valid;
  logic [3:0]  ch_in_ready;
  logic [63:0] ch_in_data;
  logic        fifo_out_valid;
  logic        fifo_out_ready;
  logic [15:0] fifo_out_data;
  logic        busy;

  glip_out_arbiter #(.WIDTH(16), .CHANNELS(4), .FIFO_DEPTH(16), .MAX_BURST(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ch_in_valid    (ch_in_valid),
    .ch_in_ready    (ch_in_ready),
    .ch_in_data     (ch_in_data),
    .fifo_out_valid (fifo_out_valid),
    .fifo_out_ready (fifo_out_ready),
    .fifo_out_data  (fifo_out_data),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  logic [15:0] exp_q[$];
  int checks   = 0;
  int errors   = 0;
  int accepted = 0;
  logic        stall_seen = 1'b0;
  logic [15:0] stall_data = '0;

  // Monitor: pops the scoreboard on every accepted word and checks hold-while-stalled.
  initial begin
    logic [15:0] exp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_seen = 1'b0;
      end else begin
        if (stall_seen) begin
          checks++;
          if (!fifo_out_valid || fifo_out_data !== stall_data) begin
            errors++;
            $display("FAIL hold_stable: got valid=%0b data=%h required valid=1 data=%h",
                     fifo_out_valid, fifo_out_data, stall_data);
          end
        end
        if (fifo_out_valid && fifo_out_ready) begin
          accepted++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got %h required no output", fifo_out_data);
          end else begin
            exp = exp_q.pop_front();
            if (fifo_out_data !== exp) begin
              errors++;
              $display("FAIL out_word_%0d: got %h required %h", accepted, fifo_out_data, exp);
            end
          end
        end
        stall_seen = fifo_out_valid && !fifo_out_ready;
        stall_data = fifo_out_data;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input int ch, input logic [15:0] d);
    bit ok;
    ok = 1'b0;
    ch_in_valid[ch] = 1'b1;
    ch_in_data[ch*16 +: 16] = d;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ch_in_ready[ch]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: ch%0d ready stayed 0 required 1", ch);
    end
    tick();
    ch_in_valid[ch] = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_drain: got %0d words pending busy=%0b required 0 pending busy=0",
               name, exp_q.size(), busy);
    end
    tick();
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    bit ok;
    int saw;
    rst_n          = 1'b0;
    ch_in_valid    = '0;
    ch_in_data     = '0;
    fifo_out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(fifo_out_valid), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_ready", 32'(ch_in_ready), 32'hf);
    check("rst_data",  32'(fifo_out_data), 32'h0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 32'(fifo_out_valid), 32'h0);
    check("post_rst_ready", 32'(ch_in_ready), 32'hf);
    tick();

    // Channel 2 three words, behind a stalled ch0 blocker
    exp_q.push_back(16'h0100); exp_q.push_back(16'hB000);
    exp_q.push_back(16'h0302); exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222); exp_q.push_back(16'h3333);
    push_one(0, 16'hB000);
    repeat (3) tick();
    push_one(2, 16'h1111);
    push_one(2, 16'h2222);
    push_one(2, 16'h3333);
    fifo_out_ready = 1'b1;
    wait_drain("ch2_three");
    check("idle_valid", 32'(fifo_out_valid), 32'h0);

    // Round robin over channels 0,1,3 from rr_ptr=0
    do_reset(1);
    tick();
    exp_q.push_back(16'h0100); exp_q.push_back(16'hA000);
    exp_q.push_back(16'h0101); exp_q.push_back(16'hA001);
    exp_q.push_back(16'h0103); exp_q.push_back(16'hA003);
    ch_in_valid = 4'b1011;
    ch_in_data  = {16'hA003, 16'h0000, 16'hA001, 16'hA000};
    tick();
    ch_in_valid = '0;
    wait_drain("rr_order");

    // Channel 0, twenty words split by MAX_BURST
    fifo_out_ready = 1'b0;
    exp_q.push_back(16'h0103); exp_q.push_back(16'hB003);
    exp_q.push_back(16'h0800);
    for (int i = 0; i < 8; i++) exp_q.push_back(16'h4000 + 16'(i));
    exp_q.push_back(16'h0800);
    for (int i = 8; i < 16; i++) exp_q.push_back(16'h4000 + 16'(i));
    exp_q.push_back(16'h0400);
    for (int i = 16; i < 20; i++) exp_q.push_back(16'h4000 + 16'(i));
    push_one(3, 16'hB003);
    repeat (3) tick();
    for (int i = 0; i < 16; i++) push_one(0, 16'h4000 + 16'(i));
    fifo_out_ready = 1'b1;
    for (int i = 16; i < 20; i++) push_one(0, 16'h4000 + 16'(i));
    wait_drain("burst_split");

    // Channel 1 filled to full, ready returns the cycle after the first pop
    fifo_out_ready = 1'b0;
    exp_q.push_back(16'h0101); exp_q.push_back(16'h5000);
    exp_q.push_back(16'h0801);
    for (int i = 1; i < 9; i++) exp_q.push_back(16'h5000 + 16'(i));
    exp_q.push_back(16'h0701);
    for (int i = 9; i < 16; i++) exp_q.push_back(16'h5000 + 16'(i));
    for (int i = 0; i < 16; i++) push_one(1, 16'h5000 + 16'(i));
    @(negedge clk);
    check("full_ready_low", 32'(ch_in_ready[1]), 32'h0);
    tick();
    fifo_out_ready = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (fifo_out_valid && fifo_out_ready && fifo_out_data == 16'h5000) begin
        ok = 1'b1;
        break;
      end
    end
    check("first_pop_seen", 32'(ok), 32'h1);
    check("ready_at_pop", 32'(ch_in_ready[1]), 32'h0);
    @(negedge clk);
    check("ready_after_pop", 32'(ch_in_ready[1]), 32'h1);
    tick();
    wait_drain("full_ch1");

    // Random back-pressure during payload
    fifo_out_ready = 1'b0;
    exp_q.push_back(16'h0100); exp_q.push_back(16'hB100);
    exp_q.push_back(16'h0802);
    for (int i = 0; i < 8; i++) exp_q.push_back(16'h6000 + 16'(i));
    push_one(0, 16'hB100);
    repeat (3) tick();
    for (int i = 0; i < 8; i++) push_one(2, 16'h6000 + 16'(i));
    for (int n = 0; n < 300; n++) begin
      fifo_out_ready = 1'($urandom_range(0, 1));
      tick();
      if (exp_q.size() == 0 && !busy) break;
    end
    fifo_out_ready = 1'b1;
    wait_drain("random_ready");

    // Reset pulse in the middle of a payload
    fifo_out_ready = 1'b0;
    exp_q.push_back(16'h0102); exp_q.push_back(16'h7000);
    exp_q.push_back(16'h0502);
    for (int i = 1; i < 6; i++) exp_q.push_back(16'h7000 + 16'(i));
    for (int i = 0; i < 6; i++) push_one(2, 16'h7000 + 16'(i));
    base = accepted;
    fifo_out_ready = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (accepted >= base + 4) begin
        ok = 1'b1;
        break;
      end
    end
    check("mid_payload_reached", 32'(ok), 32'h1);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_valid", 32'(fifo_out_valid), 32'h0);
    check("mid_rst_busy",  32'(busy), 32'h0);
    check("mid_rst_ready", 32'(ch_in_ready), 32'hf);
    check("mid_rst_data",  32'(fifo_out_data), 32'h0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("after_rst_valid", 32'(fifo_out_valid), 32'h0);
    check("after_rst_busy",  32'(busy), 32'h0);
    check("after_rst_ready", 32'(ch_in_ready), 32'hf);
    saw = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (fifo_out_valid || busy) saw++;
    end
    check("no_output_after_rst", 32'(saw), 32'h0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
